// File: rtl/axi_seq_pkg.sv
// ============================================================================
// axi_seq_pkg : sequencer state encoding and AXI constants for axi_block_seq
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } seq_state_t;

  localparam logic [1:0] INCR                   = 2'b01;
  localparam logic [2:0] SIZE_4B                = 3'b010;
  localparam logic [1:0] RESP_OKAY              = 2'b00;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

`default_nettype wire

// File: rtl/axi_seq_watchdog.sv
// ============================================================================
// axi_seq_watchdog : 8-bit stall counter, flags expiry after TIMEOUT_CYCLES
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_seq_watchdog
  import axi_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic restart,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (!active || restart) begin
      r_count <= 8'd0;
    end else if (r_count != 8'hFF) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Expiry fires in the cycle the counter would reach the limit; a handshake wins.
  assign expired = active && !restart && (r_count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/axi_block_seq.sv
// ============================================================================
// axi_block_seq : writes one INCR burst, then reads one back, over AXI4 master
// Optional watchdog with `AXI_BLOCK_SEQ_TIMEOUT_EN (adds the timeout port).
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_block_seq
  import axi_seq_pkg::*;
#(
  parameter int         BEATS          = 4,
  parameter logic [1:0] AW_ID          = 2'b11,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                m00_axi_aclk,
  input  logic                m00_axi_aresetn,
  input  logic                start,
  input  logic [5:0]          wr_addr,
  input  logic [5:0]          rd_addr,
  input  logic [32*BEATS-1:0] wr_block,
  output logic [32*BEATS-1:0] rd_block,
  output logic                busy,
  output logic                done,
  output logic                err,
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic [5:0]          m00_axi_awaddr,
  output logic [7:0]          m00_axi_awlen,
  output logic [2:0]          m00_axi_awsize,
  output logic [1:0]          m00_axi_awburst,
  output logic [1:0]          m00_axi_awid,
  output logic                m00_axi_awvalid,
  input  logic                m00_axi_awready,
  output logic [31:0]         m00_axi_wdata,
  output logic [3:0]          m00_axi_wstrb,
  output logic                m00_axi_wlast,
  output logic                m00_axi_wvalid,
  input  logic                m00_axi_wready,
  input  logic [1:0]          m00_axi_bresp,
  input  logic [1:0]          m00_axi_bid,
  input  logic                m00_axi_bvalid,
  output logic                m00_axi_bready,
  output logic [5:0]          m00_axi_araddr,
  output logic [7:0]          m00_axi_arlen,
  output logic [2:0]          m00_axi_arsize,
  output logic [1:0]          m00_axi_arburst,
  output logic                m00_axi_arvalid,
  input  logic                m00_axi_arready,
  input  logic [31:0]         m00_axi_rdata,
  input  logic [1:0]          m00_axi_rresp,
  input  logic                m00_axi_rlast,
  input  logic                m00_axi_rvalid,
  output logic                m00_axi_rready
);

  if (BEATS < 1 || BEATS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("axi_block_seq: BEATS must be 1..8 and TIMEOUT_CYCLES 1..255");
  end

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  seq_state_t          r_state;
  logic [2:0]          r_beat;
  logic [32*BEATS-1:0] r_wr_buf;

  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_last_beat;
  logic [2:0] w_next_beat;
  logic       w_expired;

  assign w_aw_hs     = m00_axi_awvalid & m00_axi_awready;
  assign w_w_hs      = m00_axi_wvalid  & m00_axi_wready;
  assign w_b_hs      = m00_axi_bvalid  & m00_axi_bready;
  assign w_ar_hs     = m00_axi_arvalid & m00_axi_arready;
  assign w_r_hs      = m00_axi_rvalid  & m00_axi_rready;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_next_beat = r_beat + 3'd1;

`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
  logic w_wd_active;
  logic w_wd_restart;

  assign w_wd_active  = r_state inside {S_AW, S_W, S_B, S_AR, S_R};
  assign w_wd_restart = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

  axi_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (m00_axi_aclk),
    .rst_n   (m00_axi_aresetn),
    .active  (w_wd_active),
    .restart (w_wd_restart),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state         <= S_IDLE;
      r_beat          <= 3'd0;
      r_wr_buf        <= '0;
      rd_block        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
      timeout         <= 1'b0;
`endif
      m00_axi_awaddr  <= 6'd0;
      m00_axi_awlen   <= 8'd0;
      m00_axi_awsize  <= 3'd0;
      m00_axi_awburst <= 2'd0;
      m00_axi_awid    <= 2'd0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= 32'd0;
      m00_axi_wstrb   <= 4'd0;
      m00_axi_wlast   <= 1'b0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= 6'd0;
      m00_axi_arlen   <= 8'd0;
      m00_axi_arsize  <= 3'd0;
      m00_axi_arburst <= 2'd0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_expired) begin
        // Abandon the stalled channel: drop every valid/ready and finish with an error.
        r_state         <= S_DONE;
        r_beat          <= 3'd0;
        m00_axi_awvalid <= 1'b0;
        m00_axi_wvalid  <= 1'b0;
        m00_axi_wlast   <= 1'b0;
        m00_axi_bready  <= 1'b0;
        m00_axi_arvalid <= 1'b0;
        m00_axi_rready  <= 1'b0;
        err             <= 1'b1;
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
        timeout         <= 1'b1;
`endif
        done            <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state         <= S_AW;
              r_beat          <= 3'd0;
              r_wr_buf        <= wr_block;
              busy            <= 1'b1;
              err             <= 1'b0;
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
              timeout         <= 1'b0;
`endif
              m00_axi_awaddr  <= wr_addr;
              m00_axi_awlen   <= 8'(BEATS - 1);
              m00_axi_awsize  <= SIZE_4B;
              m00_axi_awburst <= INCR;
              m00_axi_awid    <= AW_ID;
              m00_axi_awvalid <= 1'b1;
              m00_axi_wstrb   <= 4'hF;
              m00_axi_araddr  <= rd_addr;
              m00_axi_arlen   <= 8'(BEATS - 1);
              m00_axi_arsize  <= SIZE_4B;
              m00_axi_arburst <= INCR;
            end
          end
          S_AW: begin
            if (w_aw_hs) begin
              r_state         <= S_W;
              m00_axi_awvalid <= 1'b0;
              m00_axi_wvalid  <= 1'b1;
              m00_axi_wdata   <= r_wr_buf[31:0];
              m00_axi_wlast   <= (LAST_BEAT == 3'd0);
            end
          end
          S_W: begin
            if (w_w_hs) begin
              if (w_last_beat) begin
                r_state        <= S_B;
                r_beat         <= 3'd0;
                m00_axi_wvalid <= 1'b0;
                m00_axi_wlast  <= 1'b0;
                m00_axi_bready <= 1'b1;
              end else begin
                r_beat         <= w_next_beat;
                m00_axi_wdata  <= r_wr_buf[32*w_next_beat +: 32];
                m00_axi_wlast  <= (w_next_beat == LAST_BEAT);
              end
            end
          end
          S_B: begin
            if (w_b_hs) begin
              if (m00_axi_bresp != RESP_OKAY || m00_axi_bid != AW_ID) begin
                err <= 1'b1;
              end
              r_state         <= S_AR;
              m00_axi_bready  <= 1'b0;
              m00_axi_arvalid <= 1'b1;
            end
          end
          S_AR: begin
            if (w_ar_hs) begin
              r_state         <= S_R;
              m00_axi_arvalid <= 1'b0;
              m00_axi_rready  <= 1'b1;
            end
          end
          S_R: begin
            if (w_r_hs) begin
              rd_block[32*r_beat +: 32] <= m00_axi_rdata;
              if (m00_axi_rresp != RESP_OKAY || m00_axi_rlast != w_last_beat) begin
                err <= 1'b1;
              end
              // A misplaced rlast still ends the read so the sequencer cannot wedge.
              if (m00_axi_rlast || w_last_beat) begin
                r_state        <= S_DONE;
                r_beat         <= 3'd0;
                m00_axi_rready <= 1'b0;
                done           <= 1'b1;
              end else begin
                r_beat <= w_next_beat;
              end
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_block_seq.sv
// ============================================================================
// tb_axi_block_seq : directed self-checking bench with a simple AXI slave model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_block_seq;

  localparam int BEATS = 4;
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
  localparam int TO_CYC = 10;
`else
  localparam int TO_CYC = 255;
`endif

  localparam logic [127:0] BLK1 = 128'hEFEFEFEF_CDCDCDCD_ABABABAB_01010101;
  localparam logic [127:0] BLK2 = 128'hDEADBEEF_CAFEF00D_0BADF00D_FEEDFACE;
  localparam logic [127:0] RD1  = 128'h9ABCDEF0_12345678_FFFFFFFF_AAAAAAAA;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   wr_addr = '0;
  logic [5:0]   rd_addr = '0;
  logic [127:0] wr_block = '0;
  logic [127:0] rd_block;
  logic         busy, done, err;
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
  logic         timeout;
`endif
  logic [5:0]   awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst, awid;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid;
  logic         wready = 1'b0;
  logic [1:0]   bresp = '0;
  logic [1:0]   bid = '0;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [5:0]   araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;

  always #5 clk = ~clk;

  axi_block_seq #(
    .BEATS          (BEATS),
    .AW_ID          (2'b11),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .m00_axi_aclk    (clk),
    .m00_axi_aresetn (aresetn),
    .start           (start),
    .wr_addr         (wr_addr),
    .rd_addr         (rd_addr),
    .wr_block        (wr_block),
    .rd_block        (rd_block),
    .busy            (busy),
    .done            (done),
    .err             (err),
`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
    .timeout         (timeout),
`endif
    .m00_axi_awaddr  (awaddr),
    .m00_axi_awlen   (awlen),
    .m00_axi_awsize  (awsize),
    .m00_axi_awburst (awburst),
    .m00_axi_awid    (awid),
    .m00_axi_awvalid (awvalid),
    .m00_axi_awready (awready),
    .m00_axi_wdata   (wdata),
    .m00_axi_wstrb   (wstrb),
    .m00_axi_wlast   (wlast),
    .m00_axi_wvalid  (wvalid),
    .m00_axi_wready  (wready),
    .m00_axi_bresp   (bresp),
    .m00_axi_bid     (bid),
    .m00_axi_bvalid  (bvalid),
    .m00_axi_bready  (bready),
    .m00_axi_araddr  (araddr),
    .m00_axi_arlen   (arlen),
    .m00_axi_arsize  (arsize),
    .m00_axi_arburst (arburst),
    .m00_axi_arvalid (arvalid),
    .m00_axi_arready (arready),
    .m00_axi_rdata   (rdata),
    .m00_axi_rresp   (rresp),
    .m00_axi_rlast   (rlast),
    .m00_axi_rvalid  (rvalid),
    .m00_axi_rready  (rready)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave configuration
  int          aw_delay = 0;
  bit          aw_stuck = 1'b0;
  bit          w_toggle = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [1:0]  cfg_bid = 2'b11;
  logic [1:0]  cfg_rresp = 2'b00;
  int          rlast_at = 3;
  logic [31:0] r_words [8];

  // Slave state and transaction logs (updated on rising edges)
  bit          b_pend = 1'b0;
  bit          r_act = 1'b0;
  int          r_idx = 0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int          aw_unstable = 0, wstrb_bad = 0;
  logic [5:0]  aw_addr_log = '0, ar_addr_log = '0;
  logic [7:0]  aw_len_log = '0, ar_len_log = '0;
  logic [6:0]  aw_misc = '0;
  logic [31:0] w_data [8];
  logic [7:0]  w_last_mask = '0;
  bit          aw_hold = 1'b0;
  logic [20:0] aw_prev = '0;
  int          aw_wait = 0;
  int          done_cnt = 0;
  logic        err_early = 1'b0;

  task automatic clear_logs();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_unstable = 0; wstrb_bad = 0; w_last_mask = '0;
    for (int i = 0; i < 8; i++) w_data[i] = '0;
  endtask

  always @(posedge clk) begin
    if (!aresetn) begin
      b_pend = 1'b0; r_act = 1'b0; r_idx = 0; aw_hold = 1'b0;
    end else begin
      if (aw_hold && (!awvalid || {awaddr, awlen, awsize, awburst, awid} != aw_prev)) aw_unstable++;
      aw_hold = awvalid && !awready;
      aw_prev = {awaddr, awlen, awsize, awburst, awid};
      if (awvalid && awready) begin
        aw_cnt++;
        aw_addr_log = awaddr;
        aw_len_log  = awlen;
        aw_misc     = {awsize, awburst, awid};
      end
      if (wvalid && wready) begin
        if (w_cnt < 8) begin
          w_data[w_cnt] = wdata;
          if (wlast) w_last_mask[w_cnt] = 1'b1;
        end
        if (wstrb != 4'hF) wstrb_bad++;
        if (wlast) b_pend = 1'b1;
        w_cnt++;
      end
      if (bvalid && bready) begin
        b_pend = 1'b0;
        b_cnt++;
      end
      if (arvalid && arready) begin
        ar_cnt++;
        ar_addr_log = araddr;
        ar_len_log  = arlen;
        r_act = 1'b1;
        r_idx = 0;
      end else if (rvalid && rready) begin
        r_cnt++;
        if (rlast || r_idx == BEATS - 1) r_act = 1'b0;
        r_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (!aresetn) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
      rvalid = 1'b0; rlast = 1'b0; aw_wait = 0;
    end else begin
      if (awvalid && !aw_stuck) begin
        if (aw_wait >= aw_delay) awready = 1'b1;
        else begin
          awready = 1'b0;
          aw_wait++;
        end
      end else begin
        awready = 1'b0;
        aw_wait = 0;
      end
      wready  = w_toggle ? ~wready : 1'b1;
      bvalid  = b_pend;
      bresp   = cfg_bresp;
      bid     = cfg_bid;
      arready = arvalid && !aw_stuck;
      rvalid  = r_act;
      rdata   = r_words[r_idx % 8];
      rlast   = r_act && (r_idx == rlast_at);
      rresp   = cfg_rresp;
    end
  end

  // Call at a falling edge; lat counts cycles inclusively from the start cycle to the done cycle.
  task automatic run_seq(input logic [5:0] wa, input logic [5:0] ra, input logic [127:0] blk,
                         input int dup_at, output int lat, output logic err_seen);
    int n;
    bit seen;
    clear_logs();
    wr_addr = wa; rd_addr = ra; wr_block = blk; start = 1'b1;
    n = 1; seen = 1'b0; err_seen = 1'b0; done_cnt = 0; err_early = 1'b1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (n == 2) err_early = err;
      start = (n == dup_at);
      if (start) begin
        wr_addr  = 6'h3F;
        wr_block = ~blk;
      end
      if (done) begin
        seen = 1'b1;
        done_cnt++;
        err_seen = err;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1'b1);
    lat = seen ? n : -1;
    repeat (6) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
  endtask

  int   lat;
  logic e;
  bit   found;
  int   rst_done;

  initial begin
    r_words[0] = 32'hAAAAAAAA; r_words[1] = 32'hFFFFFFFF;
    r_words[2] = 32'h12345678; r_words[3] = 32'h9ABCDEF0;
    for (int i = 4; i < 8; i++) r_words[i] = 32'h0;
    for (int i = 0; i < 8; i++) w_data[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_status", {busy, done, err}, 3'b000);
    check("rst_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'b0);
    check("rst_aw", {awaddr, awlen, awsize, awburst, awid}, 21'd0);
    check("rst_ar", {araddr, arlen, arsize, arburst}, 19'd0);
    check("rst_rd_block", rd_block, 128'd0);
    aresetn = 1'b1;
    @(negedge clk);

    // Nominal sequence, slave always ready
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t1_latency", lat, 13);
    check("t1_done_once", done_cnt, 1);
    check("t1_err", e, 1'b0);
    check("t1_awaddr", aw_addr_log, 6'h08);
    check("t1_aw_ctl", {aw_len_log, aw_misc}, {8'd3, 3'b010, 2'b01, 2'b11});
    check("t1_wbeats", w_cnt, 4);
    check("t1_wdata", {w_data[3], w_data[2], w_data[1], w_data[0]}, BLK1);
    check("t1_wlast", w_last_mask, 8'b0000_1000);
    check("t1_wstrb", wstrb_bad, 0);
    check("t1_ar", {ar_addr_log, ar_len_log}, {6'h04, 8'd3});
    check("t1_rd_block", rd_block, RD1);
    check("t1_busy_after", busy, 1'b0);

    // Delayed awready, toggling wready, a start while busy
    aw_delay = 3; w_toggle = 1'b1;
    run_seq(6'h10, 6'h04, BLK2, 2, lat, e);
    check("t2_aw_stable", aw_unstable, 0);
    check("t2_aw_once", aw_cnt, 1);
    check("t2_awaddr", aw_addr_log, 6'h10);
    check("t2_wbeats", w_cnt, 4);
    check("t2_wdata", {w_data[3], w_data[2], w_data[1], w_data[0]}, BLK2);
    check("t2_wlast", w_last_mask, 8'b0000_1000);
    check("t2_done_once", done_cnt, 1);
    check("t2_err", e, 1'b0);
    aw_delay = 0; w_toggle = 1'b0;

    // Error write response: read phase still runs, err clears on the next start
    cfg_bresp = 2'b10;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t3_err", e, 1'b1);
    check("t3_ar_ran", {ar_cnt[3:0], r_cnt[3:0]}, 8'h14);
    check("t3_done_once", done_cnt, 1);
    cfg_bresp = 2'b00;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t3_err_cleared", err_early, 1'b0);
    check("t3_err_next", e, 1'b0);

    // rlast on beat 1: read ends early with err
    rlast_at = 1; r_words[0] = 32'h11111111; r_words[1] = 32'h22222222;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t4_err", e, 1'b1);
    check("t4_rbeats", r_cnt, 2);
    check("t4_rd_block", rd_block, 128'h9ABCDEF0_12345678_22222222_11111111);
    check("t4_done_once", done_cnt, 1);
    r_words[0] = 32'hAAAAAAAA; r_words[1] = 32'hFFFFFFFF;

    // rlast never asserted: read ends after the last beat with err
    rlast_at = 7;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t5_err", e, 1'b1);
    check("t5_rbeats", r_cnt, 4);
    check("t5_rd_block", rd_block, RD1);
    rlast_at = 3;

    // Wrong bid, then bad rresp
    cfg_bid = 2'b01;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t6_bid_err", e, 1'b1);
    cfg_bid = 2'b11; cfg_rresp = 2'b10;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t6_rresp_err", e, 1'b1);
    cfg_rresp = 2'b00;

    // Reset during the second W beat
    clear_logs();
    wr_addr = 6'h08; rd_addr = 6'h04; wr_block = BLK1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (w_cnt == 1) found = 1'b1;
    end
    check("t7_second_beat", {found, wvalid}, 2'b11);
    #2 aresetn = 1'b0;
    #1;
    check("t7_status", {busy, done, err}, 3'b000);
    check("t7_valids", {awvalid, wvalid, wlast, bready, arvalid, rready}, 6'b0);
    check("t7_addr", {awaddr, awlen, awsize, awburst, awid, araddr, arlen, arsize, arburst}, 40'd0);
    check("t7_rd_block", rd_block, 128'd0);
    rst_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    aresetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) rst_done++;
    end
    check("t7_no_done", rst_done, 0);
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t8_latency", lat, 13);
    check("t8_err", e, 1'b0);
    check("t8_wdata", {w_data[3], w_data[2], w_data[1], w_data[0]}, BLK1);
    check("t8_rd_block", rd_block, RD1);

`ifdef AXI_BLOCK_SEQ_TIMEOUT_EN
    // awready never comes: watchdog ends the sequence
    aw_stuck = 1'b1;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t9_latency_le13", (lat > 0 && lat <= 13), 1'b1);
    check("t9_err", e, 1'b1);
    check("t9_timeout", timeout, 1'b1);
    check("t9_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("t9_no_aw", aw_cnt, 0);
    aw_stuck = 1'b0;
    run_seq(6'h08, 6'h04, BLK1, 0, lat, e);
    check("t9_recover", {timeout, e}, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
